// File: rtl/press_counter_pkg.sv
// press_counter_pkg: shared FSM encoding and value width for the press counter and its decoder.
package press_counter_pkg;
  localparam int VALUE_W = 4;
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;
endpackage

// File: rtl/switch_press_counter_debounce_filter.sv
// debounce_filter: 2-flop synchroniser plus a four-state debounce FSM for one push-button.
// o_state[1] is the debounced level; o_rise strobes on the cycle a press is accepted.
module debounce_filter
  import press_counter_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_switch,
  output state_t o_state,
  output logic   o_rise
);
  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);
  logic s1_q, sw_sync_q;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic at_limit;
  always_comb begin
    at_limit = cnt_q == LAST;
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      RELEASED:     if (sw_sync_q) state_d = PRESS_WAIT;
      PRESS_WAIT:   if (!sw_sync_q) state_d = RELEASED;
                    else if (at_limit) state_d = PRESSED;
                    else cnt_d = cnt_q + 1'b1;
      PRESSED:      if (!sw_sync_q) state_d = RELEASE_WAIT;
      RELEASE_WAIT: if (sw_sync_q) state_d = PRESSED;
                    else if (at_limit) state_d = RELEASED;
                    else cnt_d = cnt_q + 1'b1;
      default:      state_d = RELEASED;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q      <= 1'b0;
      sw_sync_q <= 1'b0;
      state_q   <= RELEASED;
      cnt_q     <= '0;
    end else begin
      s1_q      <= i_switch;
      sw_sync_q <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end
  assign o_state = state_q;
  assign o_rise  = state_q == PRESS_WAIT && sw_sync_q && at_limit;
endmodule

// File: rtl/switch_press_counter.sv
// switch_press_counter: debounced push-button press counter feeding a 4-bit decoder value.
// Define PRESS_AUTO_REPEAT_EN to add auto-repeat counting while the button stays held.
module switch_press_counter
  import press_counter_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int MAX_COUNT      = 15,
  parameter int REPEAT_LIMIT   = 12500000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_switch,
  output logic [VALUE_W-1:0] o_value,
  output logic               o_press_pulse
);
  state_t state;
  logic rise, rep_fire, ev;
  logic [VALUE_W-1:0] value_q, value_d;
  logic pulse_q, pulse_d;
  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_filter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_switch (i_switch),
    .o_state  (state),
    .o_rise   (rise)
  );
`ifdef PRESS_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_LIMIT);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_LIMIT - 1);
  logic [RW-1:0] rep_q, rep_d;
  always_comb begin
    rep_fire = state == PRESSED && rep_q == REP_LAST;
    rep_d = (state == PRESSED && !rep_fire) ? rep_q + 1'b1 : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rep_q <= '0;
    else rep_q <= rep_d;
  end
`else
  localparam int unused_repeat_limit = REPEAT_LIMIT;
  logic unused_state;
  assign unused_state = ^state;
  assign rep_fire = 1'b0;
`endif
  assign ev = rise | rep_fire;
  always_comb begin
    value_d = ev ? ((value_q == VALUE_W'(MAX_COUNT)) ? '0 : value_q + 1'b1) : value_q;
    pulse_d = ev;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      value_q <= value_d;
      pulse_q <= pulse_d;
    end
  end
  assign o_value       = value_q;
  assign o_press_pulse = pulse_q;
endmodule

// File: tb/tb_switch_press_counter.sv
// tb_switch_press_counter: scoreboard bench; stimulus queues expected (value, cycle) per pulse.
module tb_switch_press_counter;
  typedef struct {int v; int c;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b0;
  logic [3:0] value;
  logic pulse;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int exp_val = 0;
  exp_t q[$];
  exp_t x;
  switch_press_counter #(.DEBOUNCE_LIMIT(4), .MAX_COUNT(15), .REPEAT_LIMIT(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_switch      (sw),
    .o_value       (value),
    .o_press_pulse (pulse)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (pulse) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got value %0d expected no pulse (cycle %0d)", value, cyc);
      end else begin
        x = q.pop_front();
        check("pulse_value", int'(value), x.v);
        check("pulse_cycle", cyc, x.c);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input int c);
    exp_val = (exp_val == 15) ? 0 : exp_val + 1;
    q.push_back('{v: exp_val, c: c});
  endtask
  task automatic press(input int h, input int gap);
    int e;
    e = cyc;
    sw = 1'b1;
    if (h >= 6) begin
      push(e + 7);
`ifdef PRESS_AUTO_REPEAT_EN
      for (int t = e + 15; t <= e + h + 2; t += 8) push(t);
`endif
    end
    tick(h);
    sw = 1'b0;
    tick(gap);
  endtask
  initial begin
    tick(1);
    check("reset_value", int'(value), 0);
    check("reset_pulse", int'(pulse), 0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("idle_value", int'(value), 0);
    press(20, 10);
    check("clean_value", int'(value), 1);
    check("clean_pending", q.size(), 0);
    sw = 1'b1; tick(2);
    sw = 1'b0; tick(2);
    sw = 1'b1; tick(2);
    sw = 1'b0; tick(2);
    press(12, 10);
    check("bounce_value", int'(value), 2);
    check("bounce_pending", q.size(), 0);
    sw = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("midreset_value", int'(value), 0);
    check("midreset_pulse", int'(pulse), 0);
    exp_val = 0;
    tick(1);
    rst_n = 1'b1;
    push(cyc + 7);
    tick(12);
    sw = 1'b0;
    tick(10);
    check("after_reset_value", int'(value), 1);
    check("after_reset_pending", q.size(), 0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_val = 0;
    tick(2);
    for (int i = 0; i < 16; i++) press(8, 10);
    check("wrap_value", int'(value), 0);
    check("wrap_pending", q.size(), 0);
    press(30, 12);
`ifdef PRESS_AUTO_REPEAT_EN
    check("hold_value", int'(value), 4);
`else
    check("hold_value", int'(value), 1);
`endif
    check("hold_pending", q.size(), 0);
    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
